// File: rtl/depth_bram_out_reader_pkg.sv
// ----------------------------------------------------------------------------
// depth_bram_out_reader_pkg
// Shared types and constants for the depth BRAM output reader.
//   state_e             : reader FSM states
//   DEPTH_LSB/DEPTH_MSB : depth byte position inside a 16-bit BRAM word
//   CONF_LSB/CONF_MSB   : confidence byte position inside a 16-bit BRAM word
// ----------------------------------------------------------------------------
package depth_bram_out_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEPTH_LSB = 0;
    localparam int unsigned DEPTH_MSB = 7;
    localparam int unsigned CONF_LSB  = 8;
    localparam int unsigned CONF_MSB  = 15;

endpackage

// File: rtl/depth_out_fifo.sv
// ----------------------------------------------------------------------------
// depth_out_fifo
// Synchronous show-ahead FIFO: pop_data always presents the oldest entry
// while empty=0, and a pop advances to the next one.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push         : write push_data (ignored when full)
//   pop          : discard the head entry (ignored when empty)
//   pop_data     : head entry
//   empty, full  : occupancy flags
//   count        : number of stored entries
// DEPTH must be a power of two, at least 2.
// ----------------------------------------------------------------------------
module depth_out_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 10,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/depth_bram_out_reader.sv
// ----------------------------------------------------------------------------
// depth_bram_out_reader
// Streams one frame of depth pixels out of one of two BRAMs onto a
// valid/ready interface with start-of-frame and end-of-line tags.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, index          : frame start pulse and BRAM select (sampled at start)
//   idle                  : no frame in progress
//   bram_addr, bram_rd_en : BRAM read port (data returns RD_LATENCY cycles later)
//   bram_rdata_0/1        : BRAM words, depth [7:0], confidence [15:8]
//   conf_thresh           : confidence threshold (mask build only)
//   out_data/valid/ready  : pixel stream
//   out_sof, out_eol      : first pixel of frame, last pixel of line
// Optional macro DEPTH_OUT_CONF_MASK_EN: pixels with confidence below
// conf_thresh are output as 0.
// ----------------------------------------------------------------------------
module depth_bram_out_reader
    import depth_bram_out_reader_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              index,
    output logic              idle,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_rd_en,
    input  logic [15:0]       bram_rdata_0,
    input  logic [15:0]       bram_rdata_1,
    input  logic [7:0]        conf_thresh,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

    state_e                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic             rd_room;
    logic             clear_cnt;
    logic [15:0]      word;
    logic [7:0]       pix;
    logic             tag_sof;
    logic             tag_eol;
    logic [9:0]       head;

    assign idle       = (state_q == ST_IDLE);
    assign bram_addr  = addr_q;
    assign word       = sel_q ? bram_rdata_1 : bram_rdata_0;
    assign fifo_push  = pipe_q[RD_LATENCY-1];
    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && out_ready;
    assign {out_sof, out_eol, out_data} = head;

`ifdef DEPTH_OUT_CONF_MASK_EN
    assign pix = (word[CONF_MSB:CONF_LSB] < conf_thresh) ? '0 : word[DEPTH_MSB:DEPTH_LSB];
`else
    logic unused_conf;
    assign unused_conf = ^{conf_thresh, word[CONF_MSB:CONF_LSB], fifo_full};
    assign pix = word[DEPTH_MSB:DEPTH_LSB];
`endif

    // Every strobe lands in the FIFO eventually, so reserving a slot per
    // read in flight guarantees the FIFO can never overflow.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_q[i]);
        end
        rd_room = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        bram_rd_en = 1'b0;
        clear_cnt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d     = index;
                    addr_d    = '0;
                    clear_cnt = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                bram_rd_en = rd_room;
                if (rd_room) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-return pipeline and pixel position counters of the output stream.
    // Tags are computed in stream order as pixels enter the buffer, so they
    // travel with their pixel through any output stall.
    always_comb begin
        pipe_d[0] = bram_rd_en;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        col_d = col_q;
        row_d = row_q;
        if (clear_cnt) begin
            col_d = '0;
            row_d = '0;
        end else if (fifo_push) begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        tag_sof = (col_q == '0) && (row_q == '0);
        tag_eol = (col_q == COL_W'(IMG_WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            pipe_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            pipe_q  <= pipe_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    depth_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({tag_sof, tag_eol, pix}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule
